// File: rtl/scudsp_dma_ctrl.sv
// scudsp_dma_ctrl: SCU DSP DMA sequencer.
// Runs one decoded DMA command as a series of 32-bit beats between the D0 bus
// and DSP data RAM bank 0-3 (or program RAM), then writes back RA0/WA0.
// Optional feature: define SCUDSP_DMA_ABORT_EN to add the "abort" input, which
// ends a transfer early after the beat in progress completes.
//
// D0 handshake: d0_req/d0_we/d0_addr are raised together and held stable
// until the cycle in which d0_ack is sampled high; d0_ack is ignored while
// d0_req is low, and an ack in the first request cycle is legal.
module scudsp_dma_ctrl #(
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_st,
    input  logic              cmd_dir,
    input  logic [1:0]        cmd_rams,
    input  logic              cmd_prg,
    input  logic [2:0]        cmd_addi,
    input  logic [7:0]        cmd_cnt,
    input  logic              cmd_hold,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] wa0,
    output logic              d0_req,
    output logic              d0_we,
    output logic [ADDR_W-1:0] d0_addr,
    output logic [31:0]       d0_do,
    input  logic [31:0]       d0_di,
    input  logic              d0_ack,
    output logic [3:0]        ram_rd,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_do,
    input  logic [31:0]       ram_di,
    output logic [3:0]        ct_inc,
    output logic              prg_we,
    output logic [7:0]        prg_addr,
    output logic              addr_wb,
    output logic [ADDR_W-1:0] addr_new,
    output logic              busy,
    output logic              done,
`ifdef SCUDSP_DMA_ABORT_EN
    input  logic              abort,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RRD  = 3'd1,
        S_RLAT = 3'd2,
        S_BREQ = 3'd3,
        S_RWR  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Latched command fields
    logic              dir_q;
    logic [1:0]        bank_q;
    logic              prg_q;
    logic [2:0]        addi_q;
    logic              hold_q;
    logic [8:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rdata_q;   // D0 read data waiting for the RAM write
    logic [31:0]       wdata_q;   // RAM read data waiting for the D0 write
    logic [7:0]        prg_addr_q;

    logic [ADDR_W-1:0] step;
    logic [3:0]        bank_oh;
    logic              abort_hit;

    // Address step: code 0 holds the address, codes 1..7 give 4..256 bytes
    always_comb begin
        step = '0;
        if (addi_q != 3'd0) begin
            step = ADDR_W'(2) << addi_q;
        end
    end

    assign bank_oh = 4'b0001 << bank_q;

`ifdef SCUDSP_DMA_ABORT_EN
    logic abort_q;

    // Remember an abort seen during a transfer until the FSM reaches FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else if (state == S_IDLE || state == S_FIN) begin
            abort_q <= 1'b0;
        end else if (abort) begin
            abort_q <= 1'b1;
        end
    end

    assign abort_hit = abort_q | (abort && state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_st) begin
                    state_nxt = cmd_dir ? S_RRD : S_BREQ;
                end
            end
            S_RRD:  state_nxt = S_RLAT;
            S_RLAT: state_nxt = S_BREQ;
            S_BREQ: begin
                if (d0_ack) begin
                    if (!dir_q) begin
                        state_nxt = S_RWR;
                    end else if (cnt_q == 9'd1 || abort_hit) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt = S_RRD;
                    end
                end
            end
            S_RWR: begin
                if (cnt_q == 9'd0 || abort_hit) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_BREQ;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; everything returns to 0 outside its own state
    always_comb begin
        d0_req   = 1'b0;
        d0_we    = 1'b0;
        d0_addr  = '0;
        ram_rd   = 4'b0000;
        ram_we   = 4'b0000;
        ct_inc   = 4'b0000;
        prg_we   = 1'b0;
        addr_wb  = 1'b0;
        addr_new = '0;
        done     = 1'b0;
        case (state)
            S_RRD: begin
                ram_rd = bank_oh;
                ct_inc = bank_oh;
            end
            S_BREQ: begin
                d0_req  = 1'b1;
                d0_we   = dir_q;
                d0_addr = addr_q;
            end
            S_RWR: begin
                if (prg_q) begin
                    prg_we = 1'b1;
                end else begin
                    ram_we = bank_oh;
                    ct_inc = bank_oh;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (!hold_q) begin
                    addr_wb  = 1'b1;
                    addr_new = addr_q;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign d0_do     = wdata_q;
    assign ram_do    = rdata_q;
    assign prg_addr  = prg_addr_q;
    assign dbg_state = state;

    // Command latch, address/count stepping and data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q      <= 1'b0;
            bank_q     <= 2'd0;
            prg_q      <= 1'b0;
            addi_q     <= 3'd0;
            hold_q     <= 1'b0;
            cnt_q      <= 9'd0;
            addr_q     <= '0;
            rdata_q    <= 32'd0;
            wdata_q    <= 32'd0;
            prg_addr_q <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_st) begin
                        dir_q      <= cmd_dir;
                        bank_q     <= cmd_rams;
                        // Program RAM is only a D0->RAM destination
                        prg_q      <= cmd_prg & ~cmd_dir;
                        addi_q     <= cmd_addi;
                        hold_q     <= cmd_hold;
                        cnt_q      <= (cmd_cnt == 8'd0) ? 9'd256 : {1'b0, cmd_cnt};
                        prg_addr_q <= 8'd0;
                        if (cmd_dir) begin
                            addr_q <= {wa0[ADDR_W-1:2], 2'b00};
                        end else begin
                            addr_q <= {ra0[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                S_RLAT: wdata_q <= ram_di;
                S_BREQ: begin
                    if (d0_ack) begin
                        addr_q <= addr_q + step;
                        cnt_q  <= cnt_q - 9'd1;
                        if (!dir_q) begin
                            rdata_q <= d0_di;
                        end
                    end
                end
                S_RWR: begin
                    if (prg_q) begin
                        prg_addr_q <= prg_addr_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scudsp_dma_ctrl.sv
// Testbench for scudsp_dma_ctrl: D0 and RAM responders feed a scoreboard of
// expected bus beats, RAM/PRG writes and address writebacks.
`timescale 1ns/1ps
module tb_scudsp_dma_ctrl;
    localparam int ADDR_W = 27;

    logic              clk;
    logic              rst;
    logic              cmd_st;
    logic              cmd_dir;
    logic [1:0]        cmd_rams;
    logic              cmd_prg;
    logic [2:0]        cmd_addi;
    logic [7:0]        cmd_cnt;
    logic              cmd_hold;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] wa0;
    logic              d0_req;
    logic              d0_we;
    logic [ADDR_W-1:0] d0_addr;
    logic [31:0]       d0_do;
    logic [31:0]       d0_di;
    logic              d0_ack;
    logic [3:0]        ram_rd;
    logic [3:0]        ram_we;
    logic [31:0]       ram_do;
    logic [31:0]       ram_di;
    logic [3:0]        ct_inc;
    logic              prg_we;
    logic [7:0]        prg_addr;
    logic              addr_wb;
    logic [ADDR_W-1:0] addr_new;
    logic              busy;
    logic              done;
    logic              abort;
    logic [2:0]        dbg_state;

    scudsp_dma_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_st(cmd_st), .cmd_dir(cmd_dir), .cmd_rams(cmd_rams), .cmd_prg(cmd_prg),
        .cmd_addi(cmd_addi), .cmd_cnt(cmd_cnt), .cmd_hold(cmd_hold),
        .ra0(ra0), .wa0(wa0),
        .d0_req(d0_req), .d0_we(d0_we), .d0_addr(d0_addr), .d0_do(d0_do),
        .d0_di(d0_di), .d0_ack(d0_ack),
        .ram_rd(ram_rd), .ram_we(ram_we), .ram_do(ram_do), .ram_di(ram_di),
        .ct_inc(ct_inc), .prg_we(prg_we), .prg_addr(prg_addr),
        .addr_wb(addr_wb), .addr_new(addr_new), .busy(busy), .done(done),
`ifdef SCUDSP_DMA_ABORT_EN
        .abort(abort),
`endif
        .dbg_state(dbg_state)
    );

    // Scoreboard queues
    logic [63:0] exp_d0_q[$];    // {we, addr, write data}
    logic [63:0] exp_wr_q[$];    // {prg_we, prg_addr, ram_we, ram_do}
    logic [63:0] exp_wb_q[$];    // writeback address
    logic [63:0] rd_data_q[$];   // data returned on D0 reads
    logic [63:0] ram_data_q[$];  // data returned on RAM reads

    int n_checks = 0;
    int n_errs   = 0;
    int done_count = 0, wb_count = 0, ct_count = 0, rd_count = 0, beats_done = 0;
    int ack_delay = 0, wait_cnt = 0;
    int exp_ct, exp_rd, start_done, start_wb, start_beats;
    logic exp_hold;
    logic [3:0] cur_bank_oh;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // Monitor plus D0/RAM responders, all sampled on the falling edge
    initial begin
        logic [63:0] obs;
        d0_ack = 1'b0;
        d0_di  = 32'd0;
        ram_di = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d0_ack   = 1'b0;
                wait_cnt = 0;
            end else begin
                if (done) done_count++;
                if (addr_wb) begin
                    wb_count++;
                    if (exp_wb_q.size() == 0) check("wb_unexpected", 1, 0);
                    else check("wb_addr", 64'(addr_new), exp_wb_q.pop_front());
                end
                if (ct_inc != 4'b0000) begin
                    ct_count++;
                    check("ct_inc_bank", 64'(ct_inc), 64'(cur_bank_oh));
                end
                if (ram_we != 4'b0000 || prg_we) begin
                    obs = {19'd0, prg_we, prg_addr, ram_we, ram_do};
                    if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                    else check("ram_write", obs, exp_wr_q.pop_front());
                end
                if (ram_rd != 4'b0000) begin
                    rd_count++;
                    check("ram_rd_bank", 64'(ram_rd), 64'(cur_bank_oh));
                    if (ram_data_q.size() == 0) check("ram_rd_unexpected", 1, 0);
                    else ram_di = ram_data_q.pop_front();
                end
                if (d0_req) begin
                    obs = {4'd0, d0_we, d0_addr, (d0_we ? d0_do : 32'd0)};
                    if (exp_d0_q.size() == 0) check("d0_unexpected", 1, 0);
                    else check("d0_beat", obs, exp_d0_q[0]);
                    if (wait_cnt >= ack_delay) begin
                        d0_ack   = 1'b1;
                        wait_cnt = 0;
                        beats_done++;
                        if (exp_d0_q.size() > 0) void'(exp_d0_q.pop_front());
                        if (!d0_we && rd_data_q.size() > 0) d0_di = rd_data_q.pop_front();
                    end else begin
                        d0_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    d0_ack   = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Build expectations for n_run beats and issue the command
    task automatic start_xfer(input logic dir, input logic [1:0] bank, input logic prg,
                              input logic [2:0] addi, input logic [7:0] cnt, input logic hold,
                              input logic [ADDR_W-1:0] base, input int dly, input int n_run);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] stp;
        logic [31:0] d;
        logic peff;
        logic [7:0] pa;
        peff = prg & ~dir;
        stp  = (addi == 3'd0) ? '0 : (ADDR_W'(4) << (addi - 3'd1));
        a    = {base[ADDR_W-1:2], 2'b00};
        for (int i = 0; i < n_run; i++) begin
            d  = $urandom;
            pa = 8'(i);
            if (!dir) begin
                rd_data_q.push_back(64'(d));
                exp_d0_q.push_back({4'd0, 1'b0, a, 32'd0});
                if (peff) exp_wr_q.push_back({19'd0, 1'b1, pa, 4'b0000, d});
                else      exp_wr_q.push_back({19'd0, 1'b0, 8'd0, 4'b0001 << bank, d});
            end else begin
                ram_data_q.push_back(64'(d));
                exp_d0_q.push_back({4'd0, 1'b1, a, d});
            end
            a = a + stp;
        end
        if (!hold) exp_wb_q.push_back(64'(a));
        exp_hold    = hold;
        exp_ct      = peff ? 0 : n_run;
        exp_rd      = dir ? n_run : 0;
        cur_bank_oh = peff ? 4'b0000 : (4'b0001 << bank);
        ack_delay   = dly;
        ct_count    = 0;
        rd_count    = 0;
        start_done  = done_count;
        start_wb    = wb_count;
        start_beats = beats_done;
        @(negedge clk);
        cmd_dir  = dir;
        cmd_rams = bank;
        cmd_prg  = prg;
        cmd_addi = addi;
        cmd_cnt  = cnt;
        cmd_hold = hold;
        ra0      = dir ? ~base : base;
        wa0      = dir ? base : ~base;
        cmd_st   = 1'b1;
        @(negedge clk);
        cmd_st   = 1'b0;
    endtask

    // Wait for completion, then check that everything expected was seen
    task automatic finish_xfer(input string tag);
        for (int i = 0; i < 6000 && done_count == start_done; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, 64'(done_count - start_done), 1);
        check({tag, "_wb_count"}, 64'(wb_count - start_wb), exp_hold ? 0 : 1);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_d0_left"}, 64'(exp_d0_q.size()), 0);
        check({tag, "_wr_left"}, 64'(exp_wr_q.size()), 0);
        check({tag, "_wb_left"}, 64'(exp_wb_q.size()), 0);
        check({tag, "_ct_count"}, 64'(ct_count), 64'(exp_ct));
        check({tag, "_rd_count"}, 64'(rd_count), 64'(exp_rd));
    endtask

    task automatic clear_queues();
        exp_d0_q.delete();
        exp_wr_q.delete();
        exp_wb_q.delete();
        rd_data_q.delete();
        ram_data_q.delete();
    endtask

    // Main sequence
    initial begin
        rst = 1'b1; cmd_st = 1'b0; cmd_dir = 1'b0; cmd_rams = 2'd0; cmd_prg = 1'b0;
        cmd_addi = 3'd0; cmd_cnt = 8'd0; cmd_hold = 1'b0; ra0 = '0; wa0 = '0; abort = 1'b0;
        cur_bank_oh = 4'b0000; exp_hold = 1'b1; exp_ct = 0; exp_rd = 0;
        start_done = 0; start_wb = 0; start_beats = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d0_req", 64'(d0_req), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_strobes", 64'({ram_rd, ram_we, ct_inc, prg_we, addr_wb}), 0);
        check("rst_data", 64'({d0_do, ram_do}), 0);
        check("rst_addr", 64'({d0_addr, addr_new, prg_addr}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // D0 -> bank1, step 4, three beats, writeback 0x10C
        start_xfer(1'b0, 2'd1, 1'b0, 3'd1, 8'd3, 1'b0, 27'h0000100, 1, 3);
        finish_xfer("d0_to_bank1");

        // Bank2 -> D0, no step, hold (no writeback)
        start_xfer(1'b1, 2'd2, 1'b0, 3'd0, 8'd2, 1'b1, 27'h0200000, 0, 2);
        finish_xfer("bank2_to_d0");

        // D0 -> program RAM, count 0 = 256 beats
        start_xfer(1'b0, 2'd0, 1'b1, 3'd2, 8'd0, 1'b0, 27'h0001000, 0, 256);
        finish_xfer("d0_to_prg");

        // Slow ACK plus an extra start pulse while busy
        start_xfer(1'b1, 2'd3, 1'b0, 3'd3, 8'd4, 1'b0, 27'h0003453, 5, 4);
        repeat (8) @(negedge clk);
        cmd_dir = 1'b0; cmd_cnt = 8'd1; cmd_rams = 2'd0; cmd_st = 1'b1;
        @(negedge clk);
        cmd_st = 1'b0;
        finish_xfer("slow_ack");

        // Reset during the request phase of beat 2
        start_xfer(1'b0, 2'd0, 1'b0, 3'd1, 8'd4, 1'b0, 27'h0000400, 2, 4);
        for (int i = 0; i < 200 && !(beats_done == start_beats + 1 && d0_req); i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_reached", 64'(d0_req), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_req", 64'(d0_req), 0);
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_strobes", 64'({ram_we, ct_inc, addr_wb, done}), 0);
        clear_queues();
        start_done = done_count;
        start_wb   = wb_count;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_done", 64'(done_count - start_done), 0);
        check("rst_mid_no_wb", 64'(wb_count - start_wb), 0);

        // Normal run after reset, largest step with address wrap
        start_xfer(1'b0, 2'd0, 1'b0, 3'd7, 8'd5, 1'b0, 27'h7FFFF02, 0, 5);
        finish_xfer("wrap");

        // Random transfers
        for (int t = 0; t < 4; t++) begin
            logic dir;
            logic [7:0] cnt;
            dir = 1'($urandom_range(0, 1));
            cnt = 8'($urandom_range(1, 6));
            start_xfer(dir, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), cnt, 1'($urandom_range(0, 1)),
                       ADDR_W'($urandom), $urandom_range(0, 3), int'(cnt));
            finish_xfer("random");
        end

`ifdef SCUDSP_DMA_ABORT_EN
        // Abort during beat 3 of 10
        start_xfer(1'b0, 2'd3, 1'b0, 3'd2, 8'd10, 1'b0, 27'h0000800, 1, 3);
        for (int i = 0; i < 200 && !(beats_done == start_beats + 2 && d0_req); i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        finish_xfer("abort");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
